// File: rtl/add_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Number of chunk cycles needed to cover the full operand width.
    function automatic int unsigned calc_nchunk(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    // Chunk index width; never narrower than one bit.
    function automatic int unsigned calc_idx_w(input int unsigned nchunk);
        int unsigned w;
        w = 1;
        if (nchunk > 1) begin
            w = int'($clog2(nchunk));
        end
        return w;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// W-bit combinational ripple-carry adder used once per cycle by add_seq.
module add_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         cin,
    output logic [W-1:0] Z,
    output logic         cout
);

    logic c;

    // Bitwise full-adder chain from LSB to MSB.
    always_comb begin
        Z = '0;
        c = cin;
        for (int unsigned i = 0; i < W; i++) begin
            Z[i] = X[i] ^ Y[i] ^ c;
            c    = (X[i] & Y[i]) | (X[i] & c) | (Y[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle add/subtract: sums CHUNK bits per clock, carrying between
// chunks in a register, with a start/done handshake.
module add_seq
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    output logic [WIDTH-1:0] Z,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned IW     = calc_idx_w(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] z_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             sum_carry;
    logic [WIDTH-1:0] res_d;

    // Select the current chunk and merge its sum into the partial result.
    always_comb begin
        a_chunk = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk = b_q[idx_q*CHUNK +: CHUNK];
        res_d   = res_q;
        res_d[idx_q*CHUNK +: CHUNK] = sum_chunk;
    end

    add_chunk #(
        .W(CHUNK)
    ) u_chunk (
        .X   (a_chunk),
        .Y   (b_chunk),
        .cin (carry_q),
        .Z   (sum_chunk),
        .cout(sum_carry)
    );

    // Control FSM with datapath registers; Z/cout/ovf load only on the last chunk.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1, so cin is overridden.
                        a_q     <= X;
                        b_q     <= sub ? ~Y : Y;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= sum_carry;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        z_q     <= res_d;
                        cout_q  <= sum_carry;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (res_d[WIDTH-1] != a_q[WIDTH-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Z    = z_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq: CHUNK=4 main instance plus CHUNK=16 and CHUNK=1.
module tb_add_seq;

    logic        clk = 1'b0;
    logic        rstb;
    logic [15:0] X, Y;
    logic        sub, cin;
    logic        st4, st16, st1;

    logic [15:0] z4, z16, z1;
    logic        co4, co16, co1;
    logic        ov4, ov16, ov1;
    logic        busy4, busy16, busy1;
    logic        done4, done16, done1;

    int n_tot = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_seq #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rstb(rstb), .start(st4), .sub(sub), .X(X), .Y(Y), .cin(cin),
        .Z(z4), .cout(co4), .ovf(ov4), .busy(busy4), .done(done4)
    );
    add_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rstb(rstb), .start(st16), .sub(sub), .X(X), .Y(Y), .cin(cin),
        .Z(z16), .cout(co16), .ovf(ov16), .busy(busy16), .done(done16)
    );
    add_seq #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rstb(rstb), .start(st1), .sub(sub), .X(X), .Y(Y), .cin(cin),
        .Z(z1), .cout(co1), .ovf(ov1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {busy, done, ovf, cout, Z} of the selected instance.
    function automatic logic [19:0] obs(input int sel);
        case (sel)
            1:       return {busy16, done16, ov16, co16, z16};
            2:       return {busy1, done1, ov1, co1, z1};
            default: return {busy4, done4, ov4, co4, z4};
        endcase
    endfunction

    // Issue one request (inputs set now, accepted at next edge) and wait for done.
    task automatic run_op(input int sel, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic c,
                          output int lat, output int bcnt, output int done_at,
                          output logic [19:0] res);
        logic [19:0] o;
        logic        both;
        X = x; Y = y; sub = s; cin = c;
        case (sel)
            1:       st16 = 1'b1;
            2:       st1  = 1'b1;
            default: st4  = 1'b1;
        endcase
        @(posedge clk); #1;
        st4 = 1'b0; st16 = 1'b0; st1 = 1'b0;
        both = 1'b0;
        lat  = 0;
        o    = obs(sel);
        bcnt = o[19] ? 1 : 0;
        while (!o[18] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            o = obs(sel);
            if (o[19]) bcnt++;
            if (o[19] && o[18]) both = 1'b1;
        end
        done_at = cyc;
        res     = o;
        check("busy_done_excl", {31'd0, both}, 32'd0);
    endtask

    int          lat, bcnt, d1, d2, k, seen;
    logic [19:0] r;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstb = 1'b0; st4 = 1'b0; st16 = 1'b0; st1 = 1'b0;
        X = '0; Y = '0; sub = 1'b0; cin = 1'b0;
        #12;
        check("reset_c4",  {12'd0, obs(0)}, 32'd0);
        check("reset_c16", {12'd0, obs(1)}, 32'd0);
        check("reset_c1",  {12'd0, obs(2)}, 32'd0);
        @(negedge clk); rstb = 1'b1;
        @(negedge clk);

        // Plain add, latency and busy length
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, lat, bcnt, d1, r);
        check("add_z",    {16'd0, r[15:0]}, 32'h5555);
        check("add_cout", {31'd0, r[16]}, 32'd0);
        check("add_ovf",  {31'd0, r[17]}, 32'd0);
        check("add_lat",  lat, 4);
        check("add_busy", bcnt, 4);
        @(posedge clk); #1;
        check("done_pulse_one", {31'd0, done4}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_z", {16'd0, z4}, 32'h5555);

        // Full carry ripple
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, d1, r);
        check("ripple_z",    {16'd0, r[15:0]}, 32'h0000);
        check("ripple_cout", {31'd0, r[16]}, 32'd1);
        check("ripple_ovf",  {31'd0, r[17]}, 32'd0);

        // Carry-in in add mode
        run_op(0, 16'h00FF, 16'h0F00, 1'b0, 1'b1, lat, bcnt, d1, r);
        check("cin_z",    {16'd0, r[15:0]}, 32'h1000);
        check("cin_cout", {31'd0, r[16]}, 32'd0);

        // Subtract with borrow, cin ignored
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, lat, bcnt, d1, r);
        check("sub_z",    {16'd0, r[15:0]}, 32'hFFFE);
        check("sub_cout", {31'd0, r[16]}, 32'd0);
        check("sub_ovf",  {31'd0, r[17]}, 32'd0);

        // Overflow, then back-to-back request issued in DONE
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, d1, r);
        check("ovf_add_z",    {16'd0, r[15:0]}, 32'h8000);
        check("ovf_add_ovf",  {31'd0, r[17]}, 32'd1);
        check("ovf_add_cout", {31'd0, r[16]}, 32'd0);
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, lat, bcnt, d2, r);
        check("ovf_sub_z",    {16'd0, r[15:0]}, 32'h7FFF);
        check("ovf_sub_ovf",  {31'd0, r[17]}, 32'd1);
        check("ovf_sub_cout", {31'd0, r[16]}, 32'd1);
        check("b2b_gap", d2 - d1, 5);

        // Start while busy is ignored
        @(negedge clk);
        X = 16'h1111; Y = 16'h2222; sub = 1'b0; cin = 1'b0; st4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0;
        @(posedge clk); #1;
        X = 16'hFFFF; Y = 16'hFFFF; sub = 1'b1; cin = 1'b1; st4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0;
        k = 0;
        while (!done4 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("busy_ign_lat",  k, 2);
        check("busy_ign_z",    {16'd0, z4}, 32'h3333);
        check("busy_ign_cout", {31'd0, co4}, 32'd0);

        // Reset in the second RUN cycle aborts
        @(negedge clk);
        X = 16'h1234; Y = 16'h1111; sub = 1'b0; cin = 1'b0; st4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b0;
        #1;
        check("rst_z",    {16'd0, z4}, 32'd0);
        check("rst_cout", {31'd0, co4}, 32'd0);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rstb = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done4 || busy4) seen++;
        end
        check("rst_no_done", seen, 0);
        run_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, lat, bcnt, d1, r);
        check("post_rst_z",   {16'd0, r[15:0]}, 32'h0007);
        check("post_rst_lat", lat, 4);

        // Single-chunk and bit-serial instances
        run_op(1, 16'hABCD, 16'h1111, 1'b0, 1'b0, lat, bcnt, d1, r);
        check("c16_z",    {16'd0, r[15:0]}, 32'hBCDE);
        check("c16_cout", {31'd0, r[16]}, 32'd0);
        check("c16_lat",  lat, 1);
        check("c16_busy", bcnt, 1);
        run_op(2, 16'hABCD, 16'h1111, 1'b0, 1'b0, lat, bcnt, d1, r);
        check("c1_z",    {16'd0, r[15:0]}, 32'hBCDE);
        check("c1_ovf",  {31'd0, r[17]}, 32'd0);
        check("c1_lat",  lat, 16);
        check("c1_busy", bcnt, 16);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Parametrised multi-cycle ripple adder/subtractor, successor to the fixed-width combinational adders.
- Processes a WIDTH-bit operand pair CHUNK bits per clock and carries between chunks in a register.
- Trades latency for area on narrow datapaths.
- Sits in the lab datapath wherever a wide add/sub is needed with a start/done handshake instead of a single-cycle result.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits summed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of processing cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rstb  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge; accepted only in IDLE or DONE.
- sub  input  1  mode, sampled with start: 0 = X+Y+cin, 1 = X-Y (cin ignored).
- X  input  WIDTH  operand A, sampled with start.
- Y  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in for add mode, sampled with start.
- Z  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the MSB; in sub mode 1 = no borrow.
- ovf  output  1  registered two's-complement signed overflow.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE state.

Behaviour:
- Reset (rstb low, asynchronous):
  - state = IDLE.
  - Z = 0, cout = 0, ovf = 0, busy = 0, done = 0.
  - Internal operand, carry and index registers cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- Accept (state IDLE or DONE, start = 1, at edge k):
  - Latch A = X.
  - Latch B = sub ? ~Y : Y.
  - Carry = sub ? 1 : cin.
  - idx = 0; next state = RUN.
- RUN:
  - Each edge adds chunk idx of A, B and carry via add_chunk.
  - Writes sum bits into the internal result register at [idx*CHUNK +: CHUNK].
  - Updates carry; idx++.
  - On the edge processing idx = NCHUNK-1:
    - Load Z from the full result.
    - Load cout from the final carry.
    - Compute ovf = (A[MSB] == B[MSB]) && (Z[MSB] != A[MSB]), using the effective B.
    - Next state = DONE.
- start while in RUN is ignored; latched operands are not disturbed.
- DONE: done = 1 for exactly one cycle.
  - start = 1: accept a new operation (back-to-back, no IDLE cycle).
  - Otherwise go to IDLE.
- Latency: start accepted at edge k -> Z/cout/ovf valid and done = 1 in the cycle after edge k+NCHUNK.
- Throughput: one operation per NCHUNK+1 cycles when start is held high.
- Result hold: Z, cout and ovf change only at the final RUN edge (or reset).
  - They hold through DONE and IDLE until the next operation completes.
  - Intermediate chunk sums are never visible on Z.
- busy = (state == RUN); busy and done are never high together.
- NCHUNK = 1 case: a single RUN cycle; latency 1 plus the DONE cycle.
- Arithmetic is modulo 2^WIDTH; carry out of each chunk feeds the next chunk with no truncation.

Decomposition:
- Shared package add_pkg:
  - State enum (IDLE, RUN, DONE).
  - Constant function computing NCHUNK and the idx width ($clog2(NCHUNK), minimum 1).
- One sub-module, add_chunk: parametrised CHUNK-bit combinational ripple adder.
  - Ports: X, Y, cin -> Z, cout.
  - Instantiated once in add_seq and reused every cycle.

Test Plan (WIDTH = 16, CHUNK = 4 unless stated):
1. Add: X=16'h1234, Y=16'h4321, cin=0, sub=0 -> Z=16'h5555, cout=0, ovf=0; done 4 cycles after start; busy high exactly 4 cycles.
2. Full carry ripple: X=16'hFFFF, Y=16'h0001, cin=0 -> Z=16'h0000, cout=1, ovf=0.
3. Subtract: X=16'h0005, Y=16'h0007, sub=1 -> Z=16'hFFFE, cout=0 (borrow), ovf=0; cin=1 during the request has no effect.
4. Overflow:
   - Add X=16'h7FFF, Y=16'h0001 -> Z=16'h8000, ovf=1, cout=0.
   - Then back-to-back start during DONE: sub X=16'h8000, Y=16'h0001 -> Z=16'h7FFF, ovf=1, cout=1; done pulses 5 cycles apart.
5. Control:
   - start with new operands while busy -> ignored; result matches the original operands.
   - rstb low on the 2nd RUN cycle -> Z=0, cout=0, busy=0 immediately, no done.
   - After release, a new add 16'h0003+16'h0004 -> Z=16'h0007.
6. Parameter sweep:
   - CHUNK=16 (NCHUNK=1): 16'hABCD+16'h1111 -> Z=16'hBCDE, done 1 cycle after start.
   - CHUNK=1: same operands -> done 16 cycles after start.
